spi_minion_core: RTL and testbench

- SPI minion front end sitting directly upstream of the SPI-to-val/rdy adapter.
- Synchronises the raw SPI pins (cs, sclk, mosi) into the system clock domain and deserialises one nbits-wide word per chip-select frame onto the adapter's push interface.
- Simultaneously serialises the adapter's pull-side status and data onto miso.
- SPI mode 0 only: cs active-low, sample on sclk rise, shift on sclk fall, MSB first.

---
 rtl/spi_minion_core_if.sv | 39 +++
 rtl/spi_minion_core.sv | 92 +++++++++
 tb/tb_spi_minion_core.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_minion_core_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_minion_core_if
// Description : SPI pins plus adapter push/pull signals for spi_minion_core.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_minion_core_if #(
    parameter int NBITS = 8
);
    logic             cs;
    logic             sclk;
    logic             mosi;
    logic             miso;
    logic             pull_en;
    logic             pull_msg_val;
    logic             pull_msg_spc;
    logic [NBITS-3:0] pull_msg_data;
    logic             push_en;
    logic             push_msg_val_wrt;
    logic             push_msg_val_rd;
    logic [NBITS-3:0] push_msg_data;
    logic             parity;
    logic             frame_err;

    // slave: the minion core itself
    modport slave (
        input  cs, sclk, mosi, pull_msg_val, pull_msg_spc, pull_msg_data,
        output miso, pull_en, push_en, push_msg_val_wrt, push_msg_val_rd,
               push_msg_data, parity, frame_err
    );

    // master: the SPI host pins and the adapter together
    modport master (
        output cs, sclk, mosi, pull_msg_val, pull_msg_spc, pull_msg_data,
        input  miso, pull_en, push_en, push_msg_val_wrt, push_msg_val_rd,
               push_msg_data, parity, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/spi_minion_core.sv
`default_nettype none
// ============================================================================
// Module      : spi_minion_core
// Description : SPI mode-0 minion; one NBITS word per cs frame, full duplex.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_minion_core #(
    parameter int NBITS = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    spi_minion_core_if.slave  bus
);
    localparam int CNT_W = $clog2(NBITS + 2);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(NBITS);
    localparam logic [CNT_W-1:0] c_cnt_sat  = CNT_W'(NBITS + 1);

    // [0] meta, [1] synced, [2] history (edge detect)
    logic [2:0]       cs_pipe_q,   cs_pipe_d;
    logic [2:0]       sclk_pipe_q, sclk_pipe_d;
    logic [1:0]       mosi_pipe_q, mosi_pipe_d;
    logic [NBITS-1:0] shreg_in_q,  shreg_in_d;
    logic [NBITS-1:0] shreg_out_q, shreg_out_d;
    logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;

    logic w_cs_sync;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_sclk_rise;
    logic w_sclk_fall;

    assign w_cs_sync   = cs_pipe_q[1];
    assign w_cs_fall   = cs_pipe_q[2] & ~cs_pipe_q[1];
    assign w_cs_rise   = ~cs_pipe_q[2] & cs_pipe_q[1];
    assign w_sclk_rise = ~sclk_pipe_q[2] & sclk_pipe_q[1];
    assign w_sclk_fall = sclk_pipe_q[2] & ~sclk_pipe_q[1];

    always_comb begin
        cs_pipe_d   = {cs_pipe_q[1:0], bus.cs};
        sclk_pipe_d = {sclk_pipe_q[1:0], bus.sclk};
        mosi_pipe_d = {mosi_pipe_q[0], bus.mosi};
        shreg_in_d  = shreg_in_q;
        shreg_out_d = shreg_out_q;
        bit_cnt_d   = bit_cnt_q;

        // cs events win over any coincident sclk edge
        if (w_cs_fall) begin
            shreg_out_d = {bus.pull_msg_val, bus.pull_msg_spc, bus.pull_msg_data};
            bit_cnt_d   = '0;
        end else if (w_cs_rise) begin
            bit_cnt_d   = '0;
        end else if (!w_cs_sync) begin
            if (w_sclk_rise) begin
                shreg_in_d = {shreg_in_q[NBITS-2:0], mosi_pipe_q[1]};
                if (bit_cnt_q != c_cnt_sat) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            if (w_sclk_fall) begin
                shreg_out_d = {shreg_out_q[NBITS-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_pipe_q   <= 3'b111;
            sclk_pipe_q <= 3'b000;
            mosi_pipe_q <= 2'b00;
            shreg_in_q  <= '0;
            shreg_out_q <= '0;
            bit_cnt_q   <= '0;
        end else begin
            cs_pipe_q   <= cs_pipe_d;
            sclk_pipe_q <= sclk_pipe_d;
            mosi_pipe_q <= mosi_pipe_d;
            shreg_in_q  <= shreg_in_d;
            shreg_out_q <= shreg_out_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign bus.miso             = ~w_cs_sync & shreg_out_q[NBITS-1];
    assign bus.pull_en          = w_cs_fall;
    assign bus.push_en          = w_cs_rise & (bit_cnt_q == c_cnt_full);
    assign bus.frame_err        = w_cs_rise & (bit_cnt_q != c_cnt_full);
    assign bus.push_msg_val_wrt = shreg_in_q[NBITS-1];
    assign bus.push_msg_val_rd  = shreg_in_q[NBITS-2];
    assign bus.push_msg_data    = shreg_in_q[NBITS-3:0];
    assign bus.parity           = ^shreg_in_q[NBITS-3:0];
endmodule
`default_nettype wire

// File: tb/tb_spi_minion_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_minion_core
// Description : Directed plus random SPI frames against a word-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_minion_core;
    localparam int NBITS = 8;
    localparam int HALF  = 5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   pull_cnt;
    int   push_cnt;
    int   err_cnt;
    logic rd_at_pull;

    spi_minion_core_if #(.NBITS(NBITS)) bus ();

    spi_minion_core #(.NBITS(NBITS)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters: each cycle a pulse is high counts once.
    always @(negedge clk) begin
        if (bus.pull_en) begin
            pull_cnt   <= pull_cnt + 1;
            rd_at_pull <= bus.push_msg_val_rd;
        end
        if (bus.push_en)   push_cnt <= push_cnt + 1;
        if (bus.frame_err) err_cnt  <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, inout logic [NBITS-1:0] rx);
        #1 bus.mosi = b;
        repeat (HALF) @(posedge clk);
        #1 rx = {rx[NBITS-2:0], bus.miso};
        bus.sclk = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 bus.sclk = 1'b0;
    endtask

    task automatic cs_low();
        @(posedge clk);
        #1 bus.cs = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(posedge clk);
        #1 bus.cs = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    task automatic frame(input logic [NBITS-1:0] word, input int npulse,
                         output logic [NBITS-1:0] rx);
        logic [NBITS-1:0] r;
        r = '0;
        cs_low();
        for (int i = 0; i < npulse; i++)
            send_bit((i < NBITS) ? word[NBITS-1-i] : 1'b0, r);
        cs_high();
        rx = r;
    endtask

    task automatic set_pull(input logic v, input logic s, input logic [NBITS-3:0] d);
        bus.pull_msg_val  = v;
        bus.pull_msg_spc  = s;
        bus.pull_msg_data = d;
    endtask

    // Word-level model of a completed frame.
    task automatic check_push(input string tag, input logic [NBITS-1:0] word);
        int d;
        d = int'(word) % (1 << (NBITS - 2));
        check({tag, "_wrt"},    32'(bus.push_msg_val_wrt), 32'((int'(word) >> (NBITS - 1)) & 1));
        check({tag, "_rd"},     32'(bus.push_msg_val_rd),  32'((int'(word) >> (NBITS - 2)) & 1));
        check({tag, "_data"},   32'(bus.push_msg_data),    32'(d));
        check({tag, "_parity"}, 32'(bus.parity),           32'($countones(d) % 2));
    endtask

    initial begin
        logic [NBITS-1:0] rx;
        logic [NBITS-1:0] word;
        logic [NBITS-1:0] prev_word;
        logic             pv, ps;
        logic [NBITS-3:0] pd;
        int p0, u0, e0;

        checks = 0; errors = 0;
        pull_cnt = 0; push_cnt = 0; err_cnt = 0; rd_at_pull = 1'b0;
        bus.cs = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
        set_pull(1'b0, 1'b0, '0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle
        repeat (10) @(posedge clk);
        #1;
        check("idle_outputs", {24'd0, bus.miso, bus.push_msg_val_wrt, bus.push_msg_val_rd,
              bus.parity, bus.push_msg_data == '0, 3'b000}, 32'h8);
        check("idle_pulses", 32'(pull_cnt + push_cnt + err_cnt), 32'd0);

        // 0xA5 in, 0xFC out
        set_pull(1'b1, 1'b1, 6'h3C);
        frame(8'hA5, 8, rx);
        check("a5_pull", 32'(pull_cnt), 32'd1);
        check("a5_push", 32'(push_cnt), 32'd1);
        check("a5_err",  32'(err_cnt),  32'd0);
        check_push("a5", 8'hA5);
        check("a5_miso_word", 32'(rx), 32'hFC);
        check("a5_miso_idle", 32'(bus.miso), 32'd0);

        // Back-to-back 0x7F then 0x01
        set_pull(1'b0, 1'b1, 6'h15);
        frame(8'h7F, 8, rx);
        check("b2b1_push", 32'(push_cnt), 32'd2);
        check_push("b2b1", 8'h7F);
        check("b2b1_miso_word", 32'(rx), 32'h55);
        frame(8'h01, 8, rx);
        check("b2b2_push", 32'(push_cnt), 32'd3);
        check("b2b2_rd_at_pull", 32'(rd_at_pull), 32'd1);
        check_push("b2b2", 8'h01);

        // Short and over-long frames
        p0 = push_cnt; e0 = err_cnt;
        frame(8'hFF, 5, rx);
        check("short_push", 32'(push_cnt - p0), 32'd0);
        check("short_err",  32'(err_cnt - e0),  32'd1);
        frame(8'hC3, 9, rx);
        check("long_push", 32'(push_cnt - p0), 32'd0);
        check("long_err",  32'(err_cnt - e0),  32'd2);
        frame(8'h96, 8, rx);
        check("recover_push", 32'(push_cnt - p0), 32'd1);
        check("recover_err",  32'(err_cnt - e0),  32'd2);
        check_push("recover", 8'h96);

        // Reset four bits into a frame
        p0 = push_cnt; e0 = err_cnt;
        rx = '0;
        cs_low();
        for (int i = 0; i < 4; i++) send_bit(1'b1, rx);
        #2 rst = 1'b1;
        #1;
        check("rst_outputs", {29'd0, bus.miso, bus.push_en, bus.frame_err}, 32'd0);
        check("rst_push_data", 32'(bus.push_msg_data), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(1'b0, rx);
        cs_high();
        check("rst_push", 32'(push_cnt - p0), 32'd0);
        check("rst_err",  32'(err_cnt - e0),  32'd1);
        set_pull(1'b1, 1'b0, 6'h2A);
        frame(8'h5A, 8, rx);
        check("post_rst_push", 32'(push_cnt - p0), 32'd1);
        check_push("post_rst", 8'h5A);
        check("post_rst_miso", 32'(rx), 32'hAA);

        // Random full-duplex frames
        prev_word = 8'h5A;
        for (int n = 0; n < 16; n++) begin
            word = NBITS'($urandom);
            pv   = 1'($urandom);
            ps   = 1'($urandom);
            pd   = (NBITS-2)'($urandom);
            set_pull(pv, ps, pd);
            p0 = pull_cnt; u0 = push_cnt; e0 = err_cnt;
            frame(word, NBITS, rx);
            check("rnd_pull", 32'(pull_cnt - p0), 32'd1);
            check("rnd_push", 32'(push_cnt - u0), 32'd1);
            check("rnd_err",  32'(err_cnt - e0),  32'd0);
            check("rnd_rd_at_pull", 32'(rd_at_pull), 32'((int'(prev_word) >> (NBITS - 2)) & 1));
            check("rnd_miso", 32'(rx), 32'((int'(pv) << (NBITS - 1)) | (int'(ps) << (NBITS - 2)) | int'(pd)));
            check_push("rnd", word);
            prev_word = word;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
